// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: valid/ready on the issue side and on the writeback side.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [3:0]       control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             div_by_zero;

  modport slave (
    input  in_valid, src_a, src_b, control, out_ready,
    output in_ready, out_valid, out, div_by_zero
  );

  modport master (
    output in_valid, src_a, src_b, control, out_ready,
    input  in_ready, out_valid, out, div_by_zero
  );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU with an iterative restoring divider; latency 1 (WIDTH+1 for a divide), one-cycle bubble when issued while draining.
// Result is held in DONE until out_ready; in_ready drops during a divide and while a result is stalled.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  seq_alu_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_DIVS = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_NEG  = 4'd8;
  localparam logic [3:0] OP_LT   = 4'd9;
  localparam logic [3:0] OP_LTE  = 4'd10;
  localparam logic [3:0] OP_GT   = 4'd11;
  localparam logic [3:0] OP_GTE  = 4'd12;
  localparam logic [3:0] OP_EQ   = 4'd13;
  localparam logic [3:0] OP_NEQ  = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             dbz_q, dbz_d;
  logic             bub_q, bub_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic             accept;
  logic             is_div;
  logic [WIDTH-1:0] div_num, div_den;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_iter, dvd_iter;

  assign bus.in_ready    = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.out         = out_q;
  assign bus.div_by_zero = dbz_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign is_div  = (bus.control == OP_DIV) || (bus.control == OP_DIVS);
  assign div_num = (bus.control == OP_DIVS) ? bus.src_b : bus.src_a;
  assign div_den = (bus.control == OP_DIVS) ? bus.src_a : bus.src_b;

  // One restoring step; the quotient bit fills the dividend register from the LSB.
  assign trial    = {rem_q, dvd_q[WIDTH-1]};
  assign q_bit    = (trial >= {1'b0, dvs_q});
  assign rem_iter = q_bit ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
  assign dvd_iter = {dvd_q[WIDTH-2:0], q_bit};

  always_comb begin
    alu_res = '0;
    case (bus.control)
      OP_ADD:  alu_res = bus.src_a + bus.src_b;
      OP_SUB:  alu_res = bus.src_a - bus.src_b;
      OP_MUL:  alu_res = bus.src_a * bus.src_b;
      OP_AND:  alu_res = bus.src_a & bus.src_b;
      OP_OR:   alu_res = bus.src_a | bus.src_b;
      OP_NOT:  alu_res[0] = (bus.src_a == '0);
      OP_NEG:  alu_res = ~bus.src_a;
      OP_LT:   alu_res[0] = (bus.src_a < bus.src_b);
      OP_LTE:  alu_res[0] = (bus.src_a <= bus.src_b);
      OP_GT:   alu_res[0] = (bus.src_a > bus.src_b);
      OP_GTE:  alu_res[0] = (bus.src_a >= bus.src_b);
      OP_EQ:   alu_res[0] = (bus.src_a == bus.src_b);
      OP_NEQ:  alu_res[0] = (bus.src_a != bus.src_b);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    dbz_d   = dbz_q;
    bub_d   = bub_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;

    case (state_q)
      S_DIVIDE: begin
        if (bub_q) begin
          bub_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          rem_d = rem_iter;
          dvd_d = dvd_iter;
          if (cnt_q == '0) begin
            state_d = S_DONE;
            out_d   = dvd_iter;
            dbz_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // Issue while draining parks one cycle in DIVIDE so out_valid always drops between results.
    if (accept) begin
      if (is_div && (div_den != '0)) begin
        dvd_d   = div_num;
        dvs_d   = div_den;
        rem_d   = '0;
        cnt_d   = CNT_W'(WIDTH - 1);
        bub_d   = 1'b0;
        state_d = S_DIVIDE;
      end else begin
        out_d   = is_div ? '1 : alu_res;
        dbz_d   = is_div;
        bub_d   = (state_q == S_DONE);
        state_d = (state_q == S_DONE) ? S_DIVIDE : S_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      dbz_q   <= 1'b0;
      bub_q   <= 1'b0;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      dbz_q   <= dbz_d;
      bub_q   <= bub_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=32 and WIDTH=8: directed cases followed by random ops against an arithmetic reference model.
module tb_seq_alu;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) if32 ();
  seq_alu_if #(.WIDTH(8))  if8 ();

  seq_alu #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(if32.slave));
  seq_alu #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(if8.slave));

  int vecs = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic f_ov(input bit w8);
    return w8 ? if8.out_valid : if32.out_valid;
  endfunction
  function automatic logic f_ir(input bit w8);
    return w8 ? if8.in_ready : if32.in_ready;
  endfunction
  function automatic logic f_dbz(input bit w8);
    return w8 ? if8.div_by_zero : if32.div_by_zero;
  endfunction
  function automatic logic [31:0] f_out(input bit w8);
    return w8 ? {24'b0, if8.out} : if32.out;
  endfunction

  task automatic drive(input bit w8, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      if8.in_valid = v; if8.control = op; if8.src_a = a[7:0]; if8.src_b = b[7:0];
    end else begin
      if32.in_valid = v; if32.control = op; if32.src_a = a; if32.src_b = b;
    end
  endtask

  task automatic set_ordy(input bit w8, input logic v);
    if (w8) if8.out_ready = v;
    else    if32.out_ready = v;
  endtask

  // Reference: what the op means in plain arithmetic, and how long it should take.
  function automatic void model(input int w, input logic [3:0] op, input logic [63:0] a_in, input logic [63:0] b_in,
                                output logic [63:0] r, output logic z, output int lat);
    logic [63:0] mask, a, b, nd, dv;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    z = 1'b0;
    lat = 1;
    case (op)
      4'd0:  r = (a + b) & mask;
      4'd1:  r = (a - b) & mask;
      4'd2:  r = (a * b) & mask;
      4'd3, 4'd4: begin
        nd = (op == 4'd3) ? a : b;
        dv = (op == 4'd3) ? b : a;
        if (dv == 0) begin
          r = mask; z = 1'b1;
        end else begin
          r = nd / dv; lat = w + 1;
        end
      end
      4'd5:  r = a & b;
      4'd6:  r = a | b;
      4'd7:  r = {63'b0, a == 0};
      4'd8:  r = ~a & mask;
      4'd9:  r = {63'b0, a < b};
      4'd10: r = {63'b0, a <= b};
      4'd11: r = {63'b0, a > b};
      4'd12: r = {63'b0, a >= b};
      4'd13: r = {63'b0, a == b};
      4'd14: r = {63'b0, a != b};
      default: r = 64'd0;
    endcase
  endfunction

  // Entered and left on a falling edge with the block idle.
  task automatic xact(input bit w8, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int stall, input string tag);
    logic [63:0] er;
    logic ez;
    int el, lat, irlow, guard;
    model(w8 ? 8 : 32, op, {32'b0, a}, {32'b0, b}, er, ez, el);
    set_ordy(w8, stall == 0);
    guard = 0;
    while (!f_ir(w8) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "/in_ready"}, {63'b0, f_ir(w8)}, 64'd1);
    drive(w8, 1'b1, op, a, b);
    @(posedge clk);
    #1 drive(w8, 1'b0, op, a, b);
    lat = 0;
    irlow = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!f_ov(w8) && !f_ir(w8)) irlow++;
    end while (!f_ov(w8) && lat < 100);
    chk({tag, "/latency"}, 64'(lat), 64'(el));
    chk({tag, "/busy_cycles"}, 64'(irlow), 64'(el - 1));
    chk({tag, "/out"}, {32'b0, f_out(w8)}, er);
    chk({tag, "/div_by_zero"}, {63'b0, f_dbz(w8)}, {63'b0, ez});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "/hold_valid"}, {63'b0, f_ov(w8)}, 64'd1);
      chk({tag, "/hold_out"}, {32'b0, f_out(w8)}, er);
      chk({tag, "/hold_in_ready"}, {63'b0, f_ir(w8)}, 64'd0);
    end
    set_ordy(w8, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    logic [3:0] op;
    logic [31:0] a, b;
    bit w8;

    reset = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    set_ordy(1'b0, 1'b1);
    set_ordy(1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("reset/out_valid32", {63'b0, if32.out_valid}, 64'd0);
    chk("reset/out32", {32'b0, if32.out}, 64'd0);
    chk("reset/dbz32", {63'b0, if32.div_by_zero}, 64'd0);
    chk("reset/out_valid8", {63'b0, if8.out_valid}, 64'd0);
    chk("reset/out8", {56'b0, if8.out}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset/in_ready32", {63'b0, if32.in_ready}, 64'd1);
    chk("reset/in_ready8", {63'b0, if8.in_ready}, 64'd1);

    xact(1'b0, 4'd0, 32'hFFFF_FFFF, 32'd1, 0, "add_wrap");
    xact(1'b0, 4'd1, 32'd0, 32'd1, 0, "sub_wrap");
    xact(1'b0, 4'd3, 32'd100, 32'd7, 0, "div_100_7");
    xact(1'b0, 4'd4, 32'd7, 32'd100, 0, "divswap_7_100");
    xact(1'b0, 4'd3, 32'd55, 32'd0, 0, "div_by_zero");
    xact(1'b0, 4'd4, 32'd0, 32'd55, 0, "divswap_by_zero");

    // Stalled compare, then a new op issued in the very cycle the stall releases.
    set_ordy(1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'd9, 32'd3, 32'd9);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("lt_hold/valid", {63'b0, if32.out_valid}, 64'd1);
    chk("lt_hold/out", {32'b0, if32.out}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lt_hold/stable_out", {32'b0, if32.out}, 64'd1);
      chk("lt_hold/stable_valid", {63'b0, if32.out_valid}, 64'd1);
      chk("lt_hold/in_ready", {63'b0, if32.in_ready}, 64'd0);
    end
    set_ordy(1'b0, 1'b1);
    drive(1'b0, 1'b1, 4'd13, 32'd5, 32'd5);
    #1 chk("chain/in_ready", {63'b0, if32.in_ready}, 64'd1);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("chain/bubble", {63'b0, if32.out_valid}, 64'd0);
    @(negedge clk);
    chk("chain/valid", {63'b0, if32.out_valid}, 64'd1);
    chk("chain/out", {32'b0, if32.out}, 64'd1);
    @(negedge clk);
    chk("chain/drained", {63'b0, if32.out_valid}, 64'd0);

    // Reset lands in the middle of a long divide.
    drive(1'b0, 1'b1, 4'd3, 32'hFFFF_FFFF, 32'd3);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (10) @(negedge clk);
    chk("midreset/busy", {63'b0, if32.in_ready}, 64'd0);
    reset = 1'b1;
    #1;
    chk("midreset/valid", {63'b0, if32.out_valid}, 64'd0);
    chk("midreset/out", {32'b0, if32.out}, 64'd0);
    chk("midreset/dbz", {63'b0, if32.div_by_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("midreset/in_ready", {63'b0, if32.in_ready}, 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if32.out_valid) seen++;
    end
    chk("midreset/no_pulse", 64'(seen), 64'd0);
    xact(1'b0, 4'd3, 32'hFFFF_FFFF, 32'd3, 0, "div_after_reset");

    xact(1'b1, 4'd2, 32'd16, 32'd17, 0, "w8_mul");
    xact(1'b1, 4'd3, 32'd200, 32'd201, 0, "w8_div");
    xact(1'b1, 4'd15, 32'd77, 32'd12, 0, "w8_reserved");
    xact(1'b1, 4'd4, 32'd3, 32'd250, 2, "w8_divswap_stall");

    for (int i = 0; i < 60; i++) begin
      w8 = i[0];
      op = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = a;
        default: b = $urandom;
      endcase
      xact(w8, op, a, b, $urandom_range(0, 3), w8 ? "rand8" : "rand32");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
